// File: rtl/block_mem_arbiter.sv
// block_mem_arbiter
//   Arbitrates NUM_PORTS cache ports onto one downstream block memory.
//   Exactly one transaction is outstanding. The FSM moves IDLE -> BUSY -> RESP -> IDLE.
//   In IDLE a winner is chosen and its request is latched.
//   BUSY drives the memory strobe until the matching completion arrives.
//   RESP pulses the winner's req_ready (read) or req_done (write) for one cycle.
//
// Parameters
//   NUM_PORTS   requesting ports, 2..8
//   ADDR_WIDTH  block-address width
//   BLOCK_BITS  block data width
//   FIXED_PRIO  0: round-robin from last_grant+1; 1: lowest index wins
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   req_ren / req_wen         per-port read / write request (ren+wen => write)
//   req_block_address         per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_din                   per-port write data, packed like the address
//   req_ready / req_done      one-cycle read-valid / write-complete pulse to the winner
//   req_dout                  shared read data, holds the last captured block
//   mem_ren / mem_wen         downstream strobes, high only in BUSY
//   mem_block_address/mem_din downstream address / write data (latched)
//   mem_ready / mem_done      downstream read-valid / write-complete
//   mem_dout                  downstream read data
module block_mem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BLOCK_BITS = 256,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_ren,
  input  logic [NUM_PORTS-1:0]             req_wen,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_block_address,
  input  logic [NUM_PORTS*BLOCK_BITS-1:0]  req_din,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             req_done,
  output logic [BLOCK_BITS-1:0]            req_dout,
  output logic                             mem_ren,
  output logic                             mem_wen,
  output logic [ADDR_WIDTH-1:0]            mem_block_address,
  output logic [BLOCK_BITS-1:0]            mem_din,
  input  logic                             mem_ready,
  input  logic                             mem_done,
  input  logic [BLOCK_BITS-1:0]            mem_dout
);

  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [NUM_PORTS-1:0]    req_any;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           win_idx;
  logic [GW-1:0]           rr_idx;
  logic                    win_found;
  logic                    op_write;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BLOCK_BITS-1:0]   din_q;
  logic [BLOCK_BITS-1:0]   dout_q;

  assign req_any = req_ren | req_wen;

  // Winner selection. Round-robin scans offsets 1..NUM_PORTS from last_grant.
  // The final offset wraps back to last_grant itself, so a lone requester is always found.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    if (FIXED_PRIO != 0) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (!win_found && req_any[k]) begin
          win_found = 1'b1;
          win_idx   = GW'(k);
        end
      end
    end else begin
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
        rr_idx = GW'((32'(last_grant) + k) % NUM_PORTS);
        if (!win_found && req_any[rr_idx]) begin
          win_found = 1'b1;
          win_idx   = rr_idx;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    req_ready = '0;
    req_done  = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        mem_ren = !op_write;
        mem_wen = op_write;
        // Only the completion matching the latched operation is honoured.
        if (op_write ? mem_done : mem_ready) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (op_write) begin
          req_done[grant] = 1'b1;
        end else begin
          req_ready[grant] = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GW'(NUM_PORTS - 1);
      grant      <= '0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      dout_q     <= '0;
    end else begin
      if (state == IDLE && win_found) begin
        grant      <= win_idx;
        last_grant <= win_idx;
        op_write   <= req_wen[win_idx];
        addr_q     <= req_block_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        din_q      <= req_din[win_idx*BLOCK_BITS +: BLOCK_BITS];
      end
      if (state == BUSY && !op_write && mem_ready) begin
        dout_q <= mem_dout;
      end
    end
  end

  assign mem_block_address = addr_q;
  assign mem_din           = din_q;
  assign req_dout          = dout_q;

endmodule
